// File: rtl/pt_pkg.sv
// pt_pkg: shared width helpers and output saturation for the Pan-Tompkins stages.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package pt_pkg;

  // Wide signed container used to hand intermediate results to the saturator.
  typedef logic signed [63:0] wide_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Recursion width: the triangle kernel has DC gain M^2, so 2*clog2(M) growth bits plus sign.
  function automatic int acc_width(input int dw, input int m);
    return dw + 2 * clog2(m) + 1;
  endfunction

  function automatic wide_t sat_hi(input int dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_lo(input int dw);
    return -(wide_t'(1) <<< (dw - 1));
  endfunction

  // Clamp v into the signed dw-bit range.
  function automatic wide_t sat_clip(input wide_t v, input int dw);
    wide_t r;
    r = v;
    if (v > sat_hi(dw)) r = sat_hi(dw);
    else if (v < sat_lo(dw)) r = sat_lo(dw);
    return r;
  endfunction

  function automatic logic sat_flag(input wide_t v, input int dw);
    return (v > sat_hi(dw)) || (v < sat_lo(dw));
  endfunction

endpackage

// File: rtl/pt_lpf_mc_if.sv
// pt_lpf_mc_if: sample-in / result-out bundle of the multichannel low-pass stage.
// Latency: none (wires only).
// Backpressure: s_ready on the input side; the output side has none.
// Ports: s_valid/s_ready/s_chan/s_data in, m_valid/m_chan/m_data/m_sat/err_chan out.
interface pt_lpf_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHAN_W     = 1
);
  logic                         s_valid;
  logic                         s_ready;
  logic [CHAN_W-1:0]            s_chan;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic                         m_valid;
  logic [CHAN_W-1:0]            m_chan;
  logic signed [DATA_WIDTH-1:0] m_data;
  logic                         m_sat;
  logic                         err_chan;

  // Filter side.
  modport slave (
    input  s_valid, s_chan, s_data,
    output s_ready, m_valid, m_chan, m_data, m_sat, err_chan
  );

  // Sample source / result consumer side.
  modport master (
    output s_valid, s_chan, s_data,
    input  s_ready, m_valid, m_chan, m_data, m_sat, err_chan
  );
endinterface

// File: rtl/pt_lpf_hist.sv
// pt_lpf_hist: per-channel circular x-history (2M deep) with per-channel write pointers.
// Latency: reads are combinational; a write lands on the next clk edge.
// Backpressure: none; the caller qualifies we.
// Ports: clk, rstn, clear, we, chan, din -> rd_m = x[n-M], rd_2m = x[n-2M] for channel chan.
module pt_lpf_hist
  import pt_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  CHANNELS   = 2,
  parameter int  DELAY_M    = 6,
  localparam int CW         = idx_width(CHANNELS),
  localparam int DEPTH      = 2 * DELAY_M,
  localparam int PW         = idx_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic                         we,
  input  logic [CW-1:0]                chan,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] rd_m,
  output logic signed [DATA_WIDTH-1:0] rd_2m
);

  logic signed [DATA_WIDTH-1:0] mem [CHANNELS][DEPTH];
  logic [PW-1:0]                ptr_q [CHANNELS];
  logic [PW-1:0]                ptr_c;
  logic [PW-1:0]                ptr_m;

  // ptr is the next slot to write, which still holds the oldest sample x[n-2M].
  assign ptr_c = ptr_q[chan];
  assign ptr_m = (ptr_c >= PW'(DELAY_M)) ? ptr_c - PW'(DELAY_M) : ptr_c + PW'(DELAY_M);
  assign rd_2m = mem[chan][ptr_c];
  assign rd_m  = mem[chan][ptr_m];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c] <= '0;
        for (int d = 0; d < DEPTH; d++) mem[c][d] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c] <= '0;
        for (int d = 0; d < DEPTH; d++) mem[c][d] <= '0;
      end
    end else if (we) begin
      mem[chan][ptr_c] <= din;
      ptr_q[chan]      <= (ptr_c == PW'(DEPTH - 1)) ? '0 : ptr_c + PW'(1);
    end
  end

endmodule

// File: rtl/pt_lpf_mc.sv
// pt_lpf_mc: time-multiplexed Pan-Tompkins low-pass, y = 2y1 - y2 + x - 2x[n-M] + x[n-2M], per channel.
// Latency: 1 cycle from accept edge to m_valid; one sample per cycle in any channel order.
// Backpressure: s_ready = en & !clear; no output backpressure, en low holds a pending result.
// Ports: clk, rstn (async, active-low), en, clear, bus (pt_lpf_mc_if.slave).
module pt_lpf_mc
  import pt_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  CHANNELS   = 2,
  parameter int  DELAY_M    = 6,
  parameter int  OUT_SHIFT  = 5,
  localparam int CW         = idx_width(CHANNELS),
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, DELAY_M),
  localparam int SW         = ACC_WIDTH + 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        clear,
  pt_lpf_mc_if.slave  bus
);

  logic                         accept;
  logic                         chan_ok;
  logic                         upd;
  logic                         bad;
  logic [CW-1:0]                ch;
  logic signed [DATA_WIDTH-1:0] x_m;
  logic signed [DATA_WIDTH-1:0] x_2m;
  logic signed [ACC_WIDTH-1:0]  y1;
  logic signed [ACC_WIDTH-1:0]  y2;
  logic signed [SW-1:0]         y1e, y2e, xe, xme, x2e;
  logic signed [ACC_WIDTH-1:0]  y_new;
  wide_t                        q_wide;

  logic signed [ACC_WIDTH-1:0]  y1_q [CHANNELS];
  logic signed [ACC_WIDTH-1:0]  y2_q [CHANNELS];

  logic                         m_vld_q;
  logic                         err_q;
  logic [CW-1:0]                m_chan_q;
  logic signed [DATA_WIDTH-1:0] m_data_q;
  logic                         m_sat_q;

  // rstn gates ready so nothing is taken while reset is held.
  assign bus.s_ready = en & ~clear & rstn;
  assign accept      = bus.s_valid & bus.s_ready;
  assign chan_ok     = int'(bus.s_chan) < CHANNELS;
  assign upd         = accept & chan_ok;
  assign bad         = accept & ~chan_ok;
  // Out-of-range channels read channel 0 harmlessly; nothing is written for them.
  assign ch          = chan_ok ? bus.s_chan : '0;

  pt_lpf_hist #(
    .DATA_WIDTH (DATA_WIDTH),
    .CHANNELS   (CHANNELS),
    .DELAY_M    (DELAY_M)
  ) u_hist (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .we    (upd),
    .chan  (ch),
    .din   (bus.s_data),
    .rd_m  (x_m),
    .rd_2m (x_2m)
  );

  // The whole update is computed in the accept cycle and state commits on that same edge,
  // so a back-to-back sample on the same channel already reads the new y and pointer.
  assign y1     = y1_q[ch];
  assign y2     = y2_q[ch];
  assign y1e    = SW'(y1);
  assign y2e    = SW'(y2);
  assign xe     = SW'(bus.s_data);
  assign xme    = SW'(x_m);
  assign x2e    = SW'(x_2m);
  // Two guard bits cover the transient terms; the true y always fits ACC_WIDTH.
  assign y_new  = ACC_WIDTH'((y1e <<< 1) - y2e + xe - (xme <<< 1) + x2e);
  assign q_wide = wide_t'(y_new >>> OUT_SHIFT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANNELS; c++) begin
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else if (upd) begin
      y1_q[ch] <= y_new;
      y2_q[ch] <= y1;
    end
  end

  // Output register holds its strobe while en is low so the result is shown once en returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_vld_q  <= 1'b0;
      err_q    <= 1'b0;
      m_chan_q <= '0;
      m_data_q <= '0;
      m_sat_q  <= 1'b0;
    end else if (en) begin
      m_vld_q <= upd;
      err_q   <= bad;
      if (upd) begin
        m_chan_q <= ch;
        m_data_q <= DATA_WIDTH'(sat_clip(q_wide, DATA_WIDTH));
        m_sat_q  <= sat_flag(q_wide, DATA_WIDTH);
      end
    end
  end

  assign bus.m_valid  = m_vld_q & en;
  assign bus.err_chan = err_q & en;
  assign bus.m_chan   = m_chan_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_sat    = m_sat_q;

endmodule

// File: tb/tb_pt_lpf_mc.sv
// tb_pt_lpf_mc: directed bench for pt_lpf_mc with a convolution model and literal spot values.
// Three channels are instantiated so the 2-bit channel index can name an invalid channel (3).
// Ports: none.
module tb_pt_lpf_mc;
  localparam int DW = 16;
  localparam int CH = 3;
  localparam int M  = 6;
  localparam int SH = 5;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rstn, en, clear;

  pt_lpf_mc_if #(.DATA_WIDTH(DW), .CHAN_W(CW)) bus ();

  pt_lpf_mc #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .DELAY_M    (M),
    .OUT_SHIFT  (SH)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- model: direct convolution with the triangle kernel ----------------
  typedef struct {
    int     chan;
    longint data;
    bit     sat;
  } res_t;

  longint xh [CH][2*M];
  res_t   exp_q [$];
  res_t   obs_q [$];
  bit     err_pend;
  int     err_seen;
  longint imp [14] = '{32, 64, 96, 128, 160, 192, 160, 128, 96, 64, 32, 0, 0, 0};

  // Impulse response of the cascaded combs: 1,2,..,M,..,2,1 (zero at tap 2M-1).
  function automatic longint kern(input int k);
    return (k < M) ? longint'(k + 1) : longint'(2 * M - 1 - k);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 2 * M; k++) xh[c][k] = 0;
  endtask

  task automatic model_step(input int c, input longint x, output longint q, output bit sat);
    longint y;
    for (int k = 2 * M - 1; k > 0; k--) xh[c][k] = xh[c][k-1];
    xh[c][0] = x;
    y = 0;
    for (int k = 0; k < 2 * M; k++) y += kern(k) * xh[c][k];
    q   = y >>> SH;
    sat = 1'b0;
    if (q > 32767) begin q = 32767; sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    res_t   e;
    res_t   o;
    longint q;
    bit     s;
    if (!rstn) begin
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_m_chan", bus.m_chan, 0);
      chk("rst_m_sat", bus.m_sat, 0);
      chk("rst_err_chan", bus.err_chan, 0);
      exp_q.delete();
      err_pend = 1'b0;
      model_clear();
    end else begin
      chk("s_ready", bus.s_ready, longint'(en && !clear));
      chk("m_valid", bus.m_valid, longint'(en && exp_q.size() > 0));
      if (bus.m_valid) begin
        o.chan = int'(bus.m_chan);
        o.data = bus.m_data;
        o.sat  = bus.m_sat;
        obs_q.push_back(o);
      end
      if (en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (bus.m_valid) begin
          chk("m_chan", bus.m_chan, e.chan);
          chk("m_data", bus.m_data, e.data);
          chk("m_sat", bus.m_sat, longint'(e.sat));
        end
      end
      chk("err_chan", bus.err_chan, longint'(err_pend && en));
      if (bus.err_chan) err_seen++;
      if (en) err_pend = 1'b0;
      if (bus.s_valid && bus.s_ready) begin
        if (int'(bus.s_chan) < CH) begin
          model_step(int'(bus.s_chan), longint'(bus.s_data), q, s);
          e.chan = int'(bus.s_chan);
          e.data = q;
          e.sat  = s;
          exp_q.push_back(e);
        end else begin
          err_pend = 1'b1;
        end
      end
      if (clear) model_clear();
    end
  end

  // ---------------- stimulus helpers ----------------
  longint gd [64];
  bit     gs [64];
  int     gn;

  task automatic gather(input int c);
    gn = 0;
    for (int i = 0; i < 64; i++) begin gd[i] = 0; gs[i] = 1'b0; end
    foreach (obs_q[i]) begin
      if (obs_q[i].chan == c && gn < 64) begin
        gd[gn] = obs_q[i].data;
        gs[gn] = obs_q[i].sat;
        gn++;
      end
    end
  endtask

  task automatic check_imp(input string name, input int c);
    gather(c);
    chk($sformatf("%s_count", name), gn, 14);
    for (int i = 0; i < 14; i++) chk($sformatf("%s[%0d]", name, i), gd[i], imp[i]);
  endtask

  task automatic send(input int c, input int x);
    bus.s_valid = 1'b1;
    bus.s_chan  = CW'(c);
    bus.s_data  = DW'(x);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic impulse(input int c);
    send(c, 1024);
    repeat (13) send(c, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int zsum;
    rstn = 1'b0; en = 1'b1; clear = 1'b0;
    bus.s_valid = 1'b0; bus.s_chan = '0; bus.s_data = '0;
    err_seen = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_low", bus.s_ready, 0);
    rstn = 1'b1;
    idle(1);

    // Impulse on ch0, back-to-back.
    obs_q.delete();
    impulse(0);
    idle(2);
    check_imp("impulse_ch0", 0);

    // DC step of 1000 on ch1.
    obs_q.delete();
    repeat (14) send(1, 1000);
    idle(2);
    gather(1);
    chk("dc_count", gn, 14);
    chk("dc_first", gd[0], 31);
    chk("dc_11th", gd[10], 1125);
    chk("dc_hold", gd[13], 1125);
    zsum = 0;
    for (int i = 0; i < 14; i++) zsum += int'(gs[i]);
    chk("dc_sat_none", zsum, 0);

    // Full-scale positive and negative steps.
    do_clear();
    obs_q.delete();
    repeat (14) send(0, 32767);
    repeat (14) send(1, -32768);
    idle(2);
    gather(0);
    chk("fs_pos_first", gd[0], 1023);
    chk("fs_pos_last_unsat", gd[7], 30719);
    chk("fs_pos_unsat_flag", gs[7], 0);
    chk("fs_pos_clamp", gd[8], 32767);
    chk("fs_pos_sat_flag", gs[8], 1);
    chk("fs_pos_hold", gd[13], 32767);
    gather(1);
    chk("fs_neg_first", gd[0], -1024);
    chk("fs_neg_clamp", gd[13], -32768);
    chk("fs_neg_sat_flag", gs[13], 1);

    // Interleaved ch0 impulse / ch1 zeros, alternating every cycle.
    do_clear();
    obs_q.delete();
    for (int i = 0; i < 14; i++) begin
      send(0, (i == 0) ? 1024 : 0);
      send(1, 0);
    end
    idle(2);
    check_imp("interleave_ch0", 0);
    gather(1);
    chk("interleave_ch1_count", gn, 14);
    zsum = 0;
    for (int i = 0; i < 14; i++) zsum += (gd[i] != 0) ? 1 : 0;
    chk("interleave_ch1_zero", zsum, 0);

    // Two-sample bursts per channel.
    do_clear();
    obs_q.delete();
    for (int b = 0; b < 7; b++) begin
      send(0, (b == 0) ? 1024 : 0);
      send(0, 0);
      send(2, 500);
      send(2, 500);
    end
    idle(2);
    check_imp("burst_ch0", 0);

    // Invalid channel mid-impulse.
    do_clear();
    obs_q.delete();
    err_seen = 0;
    send(0, 1024);
    send(3, 555);
    repeat (13) send(0, 0);
    idle(2);
    check_imp("badchan_ch0", 0);
    chk("badchan_err_pulses", err_seen, 1);
    chk("badchan_no_output", obs_q.size(), 14);

    // clear with a simultaneous sample mid-ramp.
    do_clear();
    repeat (5) send(1, 1000);
    clear = 1'b1;
    bus.s_valid = 1'b1; bus.s_chan = 2'd1; bus.s_data = 16'sd1000;
    #2;
    chk("clear_ready_low", bus.s_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; bus.s_valid = 1'b0;
    idle(1);
    obs_q.delete();
    send(1, 1024);
    send(1, 0);
    idle(2);
    gather(1);
    chk("after_clear_count", gn, 2);
    chk("after_clear_first", gd[0], 32);
    chk("after_clear_second", gd[1], 64);

    // Asynchronous reset mid-stream.
    do_clear();
    send(0, 1024);
    send(0, 0);
    send(0, 0);
    chk("pre_reset_valid", bus.m_valid, 1);
    chk("pre_reset_data", bus.m_data, 96);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", bus.m_valid, 0);
    chk("async_rst_data", bus.m_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    obs_q.delete();
    impulse(0);
    idle(2);
    check_imp("post_reset_ch0", 0);

    // en low for three cycles mid-stream, with a sample offered meanwhile.
    do_clear();
    obs_q.delete();
    send(0, 1024);
    send(0, 0);
    send(0, 0);
    en = 1'b0;
    bus.s_valid = 1'b1; bus.s_chan = 2'd0; bus.s_data = 16'sd777;
    #2;
    chk("en_low_ready", bus.s_ready, 0);
    chk("en_low_valid", bus.m_valid, 0);
    #2;
    idle(3);
    en = 1'b1;
    bus.s_valid = 1'b0;
    repeat (11) send(0, 0);
    idle(2);
    check_imp("en_gap_ch0", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
